// File: rtl/tcb_arbiter_rr2.sv
// tcb_arbiter_rr2: two-manager TCB arbiter, round-robin or fixed priority.
// Stalled grants stay locked; responses follow a DLY-deep grant-tag pipe.
module tcb_arbiter_rr2 #(
  parameter int unsigned ADR = 32,
  parameter int unsigned DAT = 32,
  parameter int unsigned DLY = 1,
  parameter bit          RR  = 1'b1
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           m0_vld,
  input  logic           m0_wen,
  input  logic [ADR-1:0] m0_adr,
  input  logic [2:0]     m0_fn3,
  input  logic [DAT-1:0] m0_wdt,
  output logic [DAT-1:0] m0_rdt,
  output logic           m0_err,
  output logic           m0_rdy,
  input  logic           m1_vld,
  input  logic           m1_wen,
  input  logic [ADR-1:0] m1_adr,
  input  logic [2:0]     m1_fn3,
  input  logic [DAT-1:0] m1_wdt,
  output logic [DAT-1:0] m1_rdt,
  output logic           m1_err,
  output logic           m1_rdy,
  output logic           s_vld,
  output logic           s_wen,
  output logic [ADR-1:0] s_adr,
  output logic [2:0]     s_fn3,
  output logic [DAT-1:0] s_wdt,
  input  logic [DAT-1:0] s_rdt,
  input  logic           s_err,
  input  logic           s_rdy
);

  logic sel;
  logic xfer;
  logic lst_q, lst_d;
  logic lck_q, lck_d;
  logic lidx_q, lidx_d;
  logic rv, ri;

  always_comb begin
    sel = lst_q;
    unique case (1'b1)
      lck_q:                         sel = lidx_q;
      !lck_q && (m0_vld ^ m1_vld):   sel = m1_vld;
      !lck_q && m0_vld && m1_vld:    sel = RR ? ~lst_q : 1'b0;
      default:                       sel = lst_q;
    endcase
  end

  assign s_vld = ~rst & (sel ? m1_vld : m0_vld);
  assign s_wen = sel ? m1_wen : m0_wen;
  assign s_adr = sel ? m1_adr : m0_adr;
  assign s_fn3 = sel ? m1_fn3 : m0_fn3;
  assign s_wdt = sel ? m1_wdt : m0_wdt;

  assign m0_rdy = ~rst & ~sel & s_rdy;
  assign m1_rdy = ~rst &  sel & s_rdy;

  assign xfer = s_vld & s_rdy;

  // A stalled grant is held until it completes, never preempted.
  always_comb begin
    lst_d  = lst_q;
    lck_d  = lck_q;
    lidx_d = lidx_q;
    if (xfer) begin
      lst_d = sel;
      lck_d = 1'b0;
    end else if (s_vld) begin
      lck_d  = 1'b1;
      lidx_d = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lst_q  <= 1'b1;
      lck_q  <= 1'b0;
      lidx_q <= 1'b0;
    end else begin
      lst_q  <= lst_d;
      lck_q  <= lck_d;
      lidx_q <= lidx_d;
    end
  end

  if (DLY == 0) begin : g_nodly
    assign rv = xfer;
    assign ri = sel;
  end else begin : g_dly
    logic [DLY-1:0] v_q;
    logic [DLY-1:0] i_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= '0;
        i_q <= '0;
      end else begin
        v_q[0] <= xfer;
        i_q[0] <= sel;
        for (int k = 1; k < DLY; k++) begin
          v_q[k] <= v_q[k-1];
          i_q[k] <= i_q[k-1];
        end
      end
    end

    assign rv = v_q[DLY-1];
    assign ri = i_q[DLY-1];
  end

  assign m0_rdt = (~rst & rv & ~ri) ? s_rdt : '0;
  assign m1_rdt = (~rst & rv &  ri) ? s_rdt : '0;
  assign m0_err = ~rst & rv & ~ri & s_err;
  assign m1_err = ~rst & rv &  ri & s_err;

endmodule

// File: tb/tb_tcb_arbiter_rr2.sv
// tb_tcb_arbiter_rr2: scoreboard bench over three arbiter configs
// (DLY=1/RR=1, DLY=2/RR=1, DLY=1/RR=0) sharing one stimulus stream.
module tb_tcb_arbiter_rr2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_vld = 1'b0, m0_wen = 1'b0;
  logic [31:0] m0_adr = '0, m0_wdt = '0;
  logic [2:0]  m0_fn3 = 3'd2;
  logic        m1_vld = 1'b0, m1_wen = 1'b0;
  logic [31:0] m1_adr = '0, m1_wdt = '0;
  logic [2:0]  m1_fn3 = 3'd2;
  logic [31:0] s_rdt = '0;
  logic        s_err = 1'b0;
  logic        s_rdy = 1'b0;

  logic [31:0] m0_rdt [3];
  logic [31:0] m1_rdt [3];
  logic        m0_err [3];
  logic        m1_err [3];
  logic        m0_rdy [3];
  logic        m1_rdy [3];
  logic        s_vld  [3];
  logic        s_wen  [3];
  logic [31:0] s_adr  [3];
  logic [2:0]  s_fn3  [3];
  logic [31:0] s_wdt  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tcb_arbiter_rr2 #(
      .ADR(32),
      .DAT(32),
      .DLY((g == 1) ? 2 : 1),
      .RR ((g == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .m0_vld(m0_vld),
      .m0_wen(m0_wen),
      .m0_adr(m0_adr),
      .m0_fn3(m0_fn3),
      .m0_wdt(m0_wdt),
      .m0_rdt(m0_rdt[g]),
      .m0_err(m0_err[g]),
      .m0_rdy(m0_rdy[g]),
      .m1_vld(m1_vld),
      .m1_wen(m1_wen),
      .m1_adr(m1_adr),
      .m1_fn3(m1_fn3),
      .m1_wdt(m1_wdt),
      .m1_rdt(m1_rdt[g]),
      .m1_err(m1_err[g]),
      .m1_rdy(m1_rdy[g]),
      .s_vld (s_vld[g]),
      .s_wen (s_wen[g]),
      .s_adr (s_adr[g]),
      .s_fn3 (s_fn3[g]),
      .s_wdt (s_wdt[g]),
      .s_rdt (s_rdt),
      .s_err (s_err),
      .s_rdy (s_rdy)
    );
  end

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          mgr;
    logic [31:0] rdt;
    logic        err;
    logic        wr;
  } sb_t;

  sb_t sbq[$];
  int  cyc    = 0;
  int  err_at = -1;
  int  tgt    = 0;
  int  n_chk  = 0;
  int  n_err  = 0;

  function automatic logic [31:0] tag(input int c);
    return 32'h1234_5600 + 32'(c);
  endfunction

  function automatic int dly_of(input int t);
    return (t == 1) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cyc%0d: got %h want %h",
               nm, tgt, cyc, got, exp);
    end
  endtask

  task automatic resp_check();
    sb_t         it;
    logic [31:0] er0, er1;
    logic        ee0, ee1, w0, w1;
    er0 = '0; er1 = '0;
    ee0 = 1'b0; ee1 = 1'b0;
    w0 = 1'b0; w1 = 1'b0;
    while (sbq.size() > 0 && sbq[0].due == cyc) begin
      it = sbq.pop_front();
      if (it.mgr == 0) begin
        er0 = it.rdt; ee0 = it.err; w0 = it.wr;
      end else begin
        er1 = it.rdt; ee1 = it.err; w1 = it.wr;
      end
    end
    if (!w0) chk("m0_rdt", m0_rdt[tgt], er0);
    if (!w1) chk("m1_rdt", m1_rdt[tgt], er1);
    chk("m0_err", 32'(m0_err[tgt]), 32'(ee0));
    chk("m1_err", 32'(m1_err[tgt]), 32'(ee1));
  endtask

  // g: manager expected on the subordinate port this cycle, -1 for none
  task automatic step(input int g);
    int d;
    @(negedge clk);
    if (rst) begin
      chk("rst_svld", 32'(s_vld[tgt]), 32'd0);
      chk("rst_rdy0", 32'(m0_rdy[tgt]), 32'd0);
      chk("rst_rdy1", 32'(m1_rdy[tgt]), 32'd0);
    end else if (g < 0) begin
      chk("idle_svld", 32'(s_vld[tgt]), 32'd0);
    end else begin
      chk("s_vld", 32'(s_vld[tgt]), 32'd1);
      chk("s_adr", s_adr[tgt], (g == 1) ? m1_adr : m0_adr);
      chk("s_wen", 32'(s_wen[tgt]), 32'((g == 1) ? m1_wen : m0_wen));
      chk("m0_rdy", 32'(m0_rdy[tgt]), 32'(g == 0 && s_rdy));
      chk("m1_rdy", 32'(m1_rdy[tgt]), 32'(g == 1 && s_rdy));
    end
    resp_check();
    if (!rst && g >= 0 && s_rdy) begin
      d = cyc + dly_of(tgt);
      sbq.push_back('{due: d, mgr: g, rdt: tag(d),
                      err: (d == err_at),
                      wr: ((g == 1) ? m1_wen : m0_wen)});
    end
    @(posedge clk);
    cyc++;
    #1;
    s_rdt = tag(cyc);
    s_err = (cyc == err_at);
  endtask

  task automatic idle(input int n);
    m0_vld = 1'b0;
    m1_vld = 1'b0;
    m0_wen = 1'b0;
    m1_wen = 1'b0;
    for (int i = 0; i < n; i++) step(-1);
  endtask

  // Reset with both managers requesting, to show the outputs are gated.
  task automatic do_reset(input int t);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    sbq.delete();
    tgt    = t;
    err_at = -1;
    m0_vld = 1'b1;
    m1_vld = 1'b1;
    s_rdy  = 1'b1;
    rst    = 1'b1;
    step(-1);
    step(-1);
    rst    = 1'b0;
    m0_vld = 1'b0;
    m1_vld = 1'b0;
  endtask

  initial begin
    // single manager read, DLY=1
    do_reset(0);
    m0_vld = 1'b1; m0_adr = 32'h8000_0000; s_rdy = 1'b1;
    step(0);
    idle(2);

    // round-robin contention, alternating grants
    do_reset(0);
    m0_adr = 32'h0000_0100; m1_adr = 32'h0000_0200;
    m0_vld = 1'b1; m1_vld = 1'b1; s_rdy = 1'b1;
    for (int i = 0; i < 6; i++) step(i % 2);
    idle(2);

    // lock under stall: m1 holds the port, m0 joins mid-stall
    do_reset(0);
    m1_vld = 1'b1; m1_adr = 32'h0000_0300; s_rdy = 1'b0;
    step(1);
    m0_vld = 1'b1; m0_adr = 32'h0000_0104;
    step(1);
    step(1);
    s_rdy = 1'b1;
    step(1);
    m1_adr = 32'h0000_0304;
    step(0);
    step(1);
    idle(2);

    // error routing, DLY=2: m0 write then m1 read
    do_reset(1);
    s_rdy  = 1'b1;
    err_at = cyc + 2;
    m0_vld = 1'b1; m0_wen = 1'b1; m0_adr = 32'h0000_0400;
    m0_wdt = 32'hDEAD_BEEF;
    step(0);
    m0_vld = 1'b0; m0_wen = 1'b0;
    m1_vld = 1'b1; m1_wen = 1'b0; m1_adr = 32'h0000_0500;
    step(1);
    idle(3);
    err_at = -1;

    // fixed priority: m0 always wins
    do_reset(2);
    m0_adr = 32'h0000_0700; m1_adr = 32'h0000_0800;
    m0_vld = 1'b1; m1_vld = 1'b1; s_rdy = 1'b1;
    for (int i = 0; i < 4; i++) step(0);
    idle(2);

    // reset while a DLY=2 response is in flight
    do_reset(1);
    m0_vld = 1'b1; m0_adr = 32'h0000_0600; s_rdy = 1'b1;
    step(0);
    sbq.delete();
    m0_vld = 1'b0;
    rst = 1'b1;
    step(-1);
    rst = 1'b0;
    idle(3);
    m0_vld = 1'b1; m1_vld = 1'b1;
    step(0);
    step(1);
    idle(3);

    chk("sb_final", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
